// File: rtl/spi_slave_reg_model.sv
// spi_slave_reg_model: SPI mode-0 slave exposing an 8-bit register map with an optional byte FIFO.
// Ports: clk/rst (sync, active-high); cs_n/sck/mosi SPI inputs, asynchronous, synchronised here;
//        miso SPI data out; frame_done one-clk pulse at the end of a frame carrying at least one data byte;
//        fifo_level FIFO occupancy.
// Build option: define SPI_SLAVE_REG_MODEL_FIFO_EN to build the FIFO behind FIFO_ADDR/LEVEL_ADDR.
// Requires f_clk >= 4x f_sck.
module spi_slave_reg_model #(
  parameter int         NUM_REGS     = 64,
  parameter int         FIFO_DEPTH   = 64,
  parameter logic [5:0] FIFO_ADDR    = 6'h09,
  parameter logic [5:0] LEVEL_ADDR   = 6'h0A,
  parameter logic [5:0] VERSION_ADDR = 6'h37,
  parameter logic [7:0] VERSION_VAL  = 8'h92,
  parameter int         AUTO_INC     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs_n,
  input  logic                          sck,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  state_t     r_state, w_next;
  logic [2:0] r_cs_s, r_sck_s;
  logic [1:0] r_mosi_s;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift, r_tx;
  logic       r_miso, r_rd, r_pend, r_got, r_frame_done;
  logic [5:0] r_addr;
  logic [7:0] r_regs [NUM_REGS];
  logic       w_cs_fall, w_cs_rise, w_active, w_sck_rise, w_sck_fall;
  logic       w_byte_end, w_load, w_wr, w_in_range, w_reg_wr;
  logic [7:0] w_byte, w_map_rd, w_rd_data;
  // The cs_n synchroniser resets to "asserted" so a frame already in flight
  // at reset release never looks like a fresh cs_n fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s   <= '0;
      r_sck_s  <= '0;
      r_mosi_s <= '0;
    end else begin
      r_cs_s   <= {r_cs_s[1:0], cs_n};
      r_sck_s  <= {r_sck_s[1:0], sck};
      r_mosi_s <= {r_mosi_s[0], mosi};
    end
  end
  assign w_cs_fall  = r_cs_s[2] & ~r_cs_s[1];
  assign w_cs_rise  = ~r_cs_s[2] & r_cs_s[1];
  assign w_active   = (r_state != S_IDLE) & ~w_cs_rise;
  assign w_sck_rise = w_active & r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall = w_active & ~r_sck_s[1] & r_sck_s[2];
  assign w_byte     = {r_shift, r_mosi_s[1]};
  assign w_byte_end = w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_load     = w_sck_fall & r_pend;
  assign w_wr       = w_byte_end & (r_state == S_DATA) & ~r_rd;
  assign w_in_range = int'(r_addr) < NUM_REGS;
  assign w_rd_data  = !w_in_range ? 8'h00 : r_addr == VERSION_ADDR ? VERSION_VAL : w_map_rd;
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) w_next = S_IDLE;
    else if (r_state == S_IDLE && w_cs_fall) w_next = S_ADDR;
    else if (r_state == S_ADDR && w_byte_end) w_next = S_DATA;
  end
  // Read data is fetched on the falling edge that presents its MSB, so a byte
  // queued at the end of a frame is never fetched and never pops the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx         <= '0;
      r_miso       <= 1'b0;
      r_rd         <= 1'b0;
      r_addr       <= '0;
      r_pend       <= 1'b0;
      r_got        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_cs_rise & r_got;
      if (w_cs_fall || w_cs_rise) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_tx      <= '0;
        r_miso    <= 1'b0;
        r_pend    <= 1'b0;
        r_got     <= 1'b0;
      end
      if (w_sck_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte[6:0];
      end
      if (w_byte_end) begin
        r_pend <= 1'b1;
        if (r_state == S_ADDR) begin
          r_rd   <= w_byte[7];
          r_addr <= w_byte[6:1];
        end else begin
          r_got <= 1'b1;
          if (AUTO_INC != 0) r_addr <= (int'(r_addr) == NUM_REGS - 1) ? 6'd0 : r_addr + 6'd1;
        end
      end
      if (w_sck_fall) begin
        r_pend         <= 1'b0;
        {r_miso, r_tx} <= w_load ? w_rd_data : {r_tx, 1'b0};
      end
    end
  end
  assign miso       = r_miso & (r_state == S_DATA);
  assign frame_done = r_frame_done;
`ifdef SPI_SLAVE_REG_MODEL_FIFO_EN
  localparam int LW = $clog2(FIFO_DEPTH);
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [LW-1:0] r_wp, r_rp;
  logic [LW:0]   r_level;
  logic          w_full, w_push, w_pop, w_flush;
  logic [7:0]    w_head, w_sat;
  assign w_full     = int'(r_level) == FIFO_DEPTH;
  assign w_push     = w_wr & (r_addr == FIFO_ADDR);
  assign w_flush    = w_wr & (r_addr == LEVEL_ADDR) & w_byte[7];
  assign w_pop      = w_load & r_rd & (r_addr == FIFO_ADDR) & (r_level != '0);
  assign w_reg_wr   = w_wr & w_in_range & (r_addr != VERSION_ADDR) & (r_addr != FIFO_ADDR) & (r_addr != LEVEL_ADDR);
  assign w_head     = (r_level != '0) ? r_mem[r_rp] : 8'h00;
  assign w_sat      = (int'(r_level) > 127) ? 8'h7F : 8'(r_level);
  assign w_map_rd   = r_addr == FIFO_ADDR ? w_head : r_addr == LEVEL_ADDR ? w_sat : r_regs[r_addr];
  assign fifo_level = r_level;
  always_ff @(posedge clk) if (w_push && !w_full) r_mem[r_wp] <= w_byte;
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push && !w_full) begin
        r_wp    <= r_wp + 1'b1;
        r_level <= r_level + 1'b1;
      end
      if (w_pop) begin
        r_rp    <= r_rp + 1'b1;
        r_level <= r_level - 1'b1;
      end
    end
  end
`else
  assign w_reg_wr   = w_wr & w_in_range & (r_addr != VERSION_ADDR);
  assign w_map_rd   = r_regs[r_addr];
  assign fifo_level = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_reg_wr) r_regs[r_addr] <= w_byte;
`ifdef SPI_SLAVE_REG_MODEL_FIFO_EN
      // Bit 4 of register 0x06 is the sticky FIFO-overflow flag.
      if (w_push && w_full) r_regs[6][4] <= 1'b1;
      if (w_flush) r_regs[6][4] <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_spi_slave_reg_model.sv
// tb_spi_slave_reg_model: directed scoreboard bench for spi_slave_reg_model.
module tb_spi_slave_reg_model;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, mosi = 1'b0, cs0_n = 1'b1, cs1_n = 1'b1;
  logic miso0, miso1, fd0, fd1;
  logic [2:0] lvl0;
  logic [6:0] lvl1;
  logic [31:0] rx;
  int n_assert = 0, n_fail = 0, fd0_cnt = 0, fd1_cnt = 0, fd_base;
  int idx_q[$];
  logic [7:0] val_q[$];
  string tag_q[$];
  spi_slave_reg_model #(.NUM_REGS(60), .FIFO_DEPTH(4), .AUTO_INC(0)) dut0 (
    .clk(clk), .rst(rst), .cs_n(cs0_n), .sck(sck), .mosi(mosi),
    .miso(miso0), .frame_done(fd0), .fifo_level(lvl0));
  spi_slave_reg_model #(.AUTO_INC(1)) dut1 (
    .clk(clk), .rst(rst), .cs_n(cs1_n), .sck(sck), .mosi(mosi),
    .miso(miso1), .frame_done(fd1), .fifo_level(lvl1));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    fd0_cnt += int'(fd0);
    fd1_cnt += int'(fd1);
  end
  task automatic chk(input string t, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask
  task automatic expect_rx(input int k, input logic [7:0] v, input string t);
    idx_q.push_back(k);
    val_q.push_back(v);
    tag_q.push_back(t);
  endtask
  task automatic drain();
    while (idx_q.size() > 0) begin
      int k;
      logic [7:0] v;
      string t;
      k = idx_q.pop_front();
      v = val_q.pop_front();
      t = tag_q.pop_front();
      chk(t, rx[31-8*k -: 8], v);
    end
  endtask
  task automatic bits(input bit sel, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = d[31-i];
      #50;
      rx[31-i] = sel ? miso1 : miso0;
      sck = 1'b1;
      #50;
      sck = 1'b0;
    end
  endtask
  task automatic spi(input bit sel, input logic [31:0] d, input int n);
    rx = '0;
    if (sel) cs1_n = 1'b0; else cs0_n = 1'b0;
    #100;
    bits(sel, d, n);
    #100;
    cs0_n = 1'b1;
    cs1_n = 1'b1;
    #200;
    drain();
  endtask
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_miso0", {7'd0, miso0}, 8'h00);
    chk("rst_miso1", {7'd0, miso1}, 8'h00);
    chk("rst_fd0", {7'd0, fd0}, 8'h00);
    chk("rst_lvl0", {5'd0, lvl0}, 8'h00);
    chk("rst_lvl1", {1'b0, lvl1}, 8'h00);
    rst = 1'b0;
    #100;
    fd_base = fd0_cnt;
    expect_rx(0, 8'h00, "addr_byte_miso");
    expect_rx(1, 8'h92, "version_rd");
    spi(0, 32'h6E00_0000, 16);
    chk("fd_once", 8'(fd0_cnt - fd_base), 8'd1);
    spi(0, 32'h6E12_0000, 16);
    expect_rx(1, 8'h92, "version_ro");
    spi(0, 32'hEE00_0000, 16);
    spi(0, 32'h22AB_0000, 16);
    expect_rx(1, 8'hAB, "wr_rd");
    spi(0, 32'hA200_0000, 16);
    spi(0, 32'h22AB_CD00, 24);
    expect_rx(1, 8'hCD, "burst_hold_0");
    expect_rx(2, 8'hCD, "burst_hold_1");
    spi(0, 32'hA200_0000, 24);
    spi(0, 32'h7C55_0000, 16);
    expect_rx(1, 8'h00, "out_of_range");
    spi(0, 32'hFC00_0000, 16);
    fd_base = fd0_cnt;
    spi(0, 32'h22F0_0000, 12);
    chk("abort_no_fd", 8'(fd0_cnt - fd_base), 8'd0);
    expect_rx(1, 8'hCD, "abort_unchanged");
    spi(0, 32'hA200_0000, 16);
    spi(1, 32'h0201_0203, 32);
    expect_rx(1, 8'h01, "ainc_r1");
    expect_rx(2, 8'h02, "ainc_r2");
    expect_rx(3, 8'h03, "ainc_r3");
    spi(1, 32'h8200_0000, 32);
    spi(1, 32'h7E11_2200, 24);
    expect_rx(1, 8'h11, "wrap_r63");
    expect_rx(2, 8'h22, "wrap_r0");
    spi(1, 32'hFE00_0000, 24);
`ifdef SPI_SLAVE_REG_MODEL_FIFO_EN
    spi(0, 32'h1211_2233, 32);
    chk("lvl3", {5'd0, lvl0}, 8'd3);
    expect_rx(1, 8'h03, "lvl_rd");
    spi(0, 32'h9400_0000, 16);
    expect_rx(1, 8'h11, "pop1");
    spi(0, 32'h9200_0000, 16);
    expect_rx(1, 8'h22, "pop2");
    spi(0, 32'h9200_0000, 16);
    expect_rx(1, 8'h33, "pop3");
    spi(0, 32'h9200_0000, 16);
    expect_rx(1, 8'h00, "pop_empty");
    spi(0, 32'h9200_0000, 16);
    chk("lvl_empty", {5'd0, lvl0}, 8'd0);
    spi(0, 32'h1201_0203, 32);
    spi(0, 32'h1204_0500, 24);
    chk("lvl_full", {5'd0, lvl0}, 8'd4);
    expect_rx(1, 8'h10, "ovf_sticky");
    spi(0, 32'h8C00_0000, 16);
    spi(0, 32'h1480_0000, 16);
    chk("lvl_flush", {5'd0, lvl0}, 8'd0);
    expect_rx(1, 8'h00, "ovf_cleared");
    spi(0, 32'h8C00_0000, 16);
`else
    spi(0, 32'h125A_0000, 16);
    expect_rx(1, 8'h5A, "plain_fifo_addr");
    spi(0, 32'h9200_0000, 16);
    spi(0, 32'h1480_0000, 16);
    expect_rx(1, 8'h80, "plain_level_addr");
    spi(0, 32'h9400_0000, 16);
    chk("lvl_tied", {5'd0, lvl0}, 8'd0);
`endif
    fd_base = fd0_cnt;
    rx = '0;
    cs0_n = 1'b0;
    #100;
    bits(0, 32'h22F0_0000, 12);
    rst = 1'b1;
    #30;
    rst = 1'b0;
    bits(0, 32'hFF00_0000, 8);
    chk("rst_abort_miso", {7'd0, miso0}, 8'h00);
    #100;
    cs0_n = 1'b1;
    #200;
    chk("rst_abort_no_fd", 8'(fd0_cnt - fd_base), 8'd0);
    expect_rx(1, 8'h00, "rst_reg_clear");
    spi(0, 32'hA200_0000, 16);
    expect_rx(1, 8'h92, "rst_version");
    spi(0, 32'hEE00_0000, 16);
    expect_rx(1, 8'h00, "rst_ainc_clear");
    spi(1, 32'h8200_0000, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
